// File: rtl/fee_config_sequencer.sv
// fee_config_sequencer: gates staged FEE register values into the trigger and
// acquisition datapath. The datapath is held in STOP and drained before any
// value changes, SET_CONFIG frames the update window, and run is released only
// once the newly applied configuration is valid.
// Optional build macro FEE_CFG_SEQ_DRAIN_TIMEOUT_EN adds a bounded DRAIN wait
// with a sticky DRAIN_TIMEOUT_ERR flag; without it DRAIN waits indefinitely.
// No handshakes: REG_MODE and DATAPATH_BUSY are sampled as levels every cycle,
// and every output is held until the sequencer itself changes it.
module fee_config_sequencer #(
    parameter int DRAIN_TIMEOUT = 1024,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [2:0]  REG_MODE,
    input  logic [15:0] REG_MAX_TRIGGER_LENGTH,
    input  logic [15:0] REG_RISING_EDGE_THRESHOLD,
    input  logic [15:0] REG_FALLING_EDGE_THRESHOLD,
    input  logic [1:0]  REG_PRE_ACQUISITION_LENGTH,
    input  logic [1:0]  REG_POST_ACQUISITION_LENGTH,
    input  logic [12:0] REG_H_GAIN_BASELINE,
    input  logic [15:0] REG_L_GAIN_BASELINE,
    input  logic        DATAPATH_BUSY,
    output logic        STOP,
    output logic        SET_CONFIG,
    output logic        ACQUIRE_MODE,
    output logic [15:0] MAX_TRIGGER_LENGTH,
    output logic [15:0] RISING_EDGE_THRESHOLD,
    output logic [15:0] FALLING_EDGE_THRESHOLD,
    output logic [1:0]  PRE_ACQUISITION_LENGTH,
    output logic [1:0]  POST_ACQUISITION_LENGTH,
    output logic [12:0] H_GAIN_BASELINE,
    output logic [15:0] L_GAIN_BASELINE,
    output logic [2:0]  SEQ_STATE,
    output logic        CONFIG_ERROR,
    output logic        DRAIN_TIMEOUT_ERR
);

    typedef enum logic [2:0] {
        ST_STOPPED = 3'd0,
        ST_RUN     = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_CONFIG  = 3'd3,
        ST_APPLY   = 3'd4
    } seq_state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES);

    seq_state_t state;
    seq_state_t next_state;
    logic [7:0] settle_cnt;
    logic       set_cfg_err;
    logic       drain_timeout;

    // Mode decode: config request outranks stop, stop outranks run.
    logic cfg_req;
    logic stop_req;
    logic run_req;
    assign cfg_req  = REG_MODE[2];
    assign stop_req = !REG_MODE[2] && REG_MODE[1];
    assign run_req  = !REG_MODE[2] && !REG_MODE[1];

    // Validity is judged on the applied copy, which is stable during settle.
    logic cfg_valid;
    assign cfg_valid = (FALLING_EDGE_THRESHOLD <= RISING_EDGE_THRESHOLD)
                    && (MAX_TRIGGER_LENGTH != 16'd0);

    logic apply_entry;
    logic settle_done;
    assign apply_entry = (state == ST_APPLY) && (settle_cnt == 8'd0);
    assign settle_done = (state == ST_APPLY) && (settle_cnt == SETTLE_LAST);

    // Control outputs are pure decodes of the state register, so STOP can
    // never be low while SET_CONFIG is high.
    assign STOP       = (state != ST_RUN);
    assign SET_CONFIG = (state == ST_CONFIG) || (state == ST_APPLY);
    assign SEQ_STATE  = state;

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= ST_STOPPED;
        else          state <= next_state;
    end

    // Next-state decision and config-error request.
    always_comb begin
        next_state  = state;
        set_cfg_err = 1'b0;
        case (state)
            ST_STOPPED: begin
                if (cfg_req)      next_state = ST_CONFIG;
                else if (run_req) next_state = ST_APPLY;
            end
            ST_RUN: begin
                if (cfg_req || stop_req || (REG_MODE[0] != ACQUIRE_MODE))
                    next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!DATAPATH_BUSY || drain_timeout) begin
                    if (cfg_req)       next_state = ST_CONFIG;
                    else if (stop_req) next_state = ST_STOPPED;
                    else               next_state = ST_APPLY;
                end
            end
            ST_CONFIG: begin
                if (!cfg_req) next_state = ST_APPLY;
            end
            ST_APPLY: begin
                if (settle_done) begin
                    if (cfg_req)        next_state = ST_CONFIG;
                    else if (stop_req)  next_state = ST_STOPPED;
                    else if (!cfg_valid) begin
                        next_state  = ST_STOPPED;
                        set_cfg_err = 1'b1;
                    end
                    else                next_state = ST_RUN;
                end
            end
            default: next_state = ST_STOPPED;
        endcase
    end

    // Settle counter: restarts on every state change, counts only in APPLY.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            settle_cnt <= 8'd0;
        else if (state != next_state)
            settle_cnt <= 8'd0;
        else if ((state == ST_APPLY) && (settle_cnt != SETTLE_LAST))
            settle_cnt <= settle_cnt + 8'd1;
    end

    // Applied configuration: captured only on the first APPLY cycle.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ACQUIRE_MODE            <= 1'b0;
            MAX_TRIGGER_LENGTH      <= 16'd0;
            RISING_EDGE_THRESHOLD   <= 16'd0;
            FALLING_EDGE_THRESHOLD  <= 16'd0;
            PRE_ACQUISITION_LENGTH  <= 2'd0;
            POST_ACQUISITION_LENGTH <= 2'd0;
            H_GAIN_BASELINE         <= 13'd0;
            L_GAIN_BASELINE         <= 16'd0;
        end else if (apply_entry) begin
            ACQUIRE_MODE            <= REG_MODE[0];
            MAX_TRIGGER_LENGTH      <= REG_MAX_TRIGGER_LENGTH;
            RISING_EDGE_THRESHOLD   <= REG_RISING_EDGE_THRESHOLD;
            FALLING_EDGE_THRESHOLD  <= REG_FALLING_EDGE_THRESHOLD;
            PRE_ACQUISITION_LENGTH  <= REG_PRE_ACQUISITION_LENGTH;
            POST_ACQUISITION_LENGTH <= REG_POST_ACQUISITION_LENGTH;
            H_GAIN_BASELINE         <= REG_H_GAIN_BASELINE;
            L_GAIN_BASELINE         <= REG_L_GAIN_BASELINE;
        end
    end

    // Sticky config error: set on a rejected run, cleared on entering CONFIG.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            CONFIG_ERROR <= 1'b0;
        else if ((state != ST_CONFIG) && (next_state == ST_CONFIG))
            CONFIG_ERROR <= 1'b0;
        else if (set_cfg_err)
            CONFIG_ERROR <= 1'b1;
    end

`ifdef FEE_CFG_SEQ_DRAIN_TIMEOUT_EN
    localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);

    logic [DW-1:0] drain_cnt;

    // The last DRAIN cycle with busy still high forces the exit.
    assign drain_timeout = (state == ST_DRAIN) && (drain_cnt == DRAIN_LAST);

    // Drain counter: zero outside DRAIN, so it starts from zero on entry.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            drain_cnt <= '0;
        else if (state != ST_DRAIN)
            drain_cnt <= '0;
        else if (drain_cnt != DRAIN_LAST)
            drain_cnt <= drain_cnt + 1'b1;
    end

    // Sticky timeout flag: only when busy never dropped.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            DRAIN_TIMEOUT_ERR <= 1'b0;
        else if (drain_timeout && DATAPATH_BUSY)
            DRAIN_TIMEOUT_ERR <= 1'b1;
    end
`else
    logic unused_drain_timeout;
    assign unused_drain_timeout = (DRAIN_TIMEOUT < 1);
    assign drain_timeout        = 1'b0;
    assign DRAIN_TIMEOUT_ERR    = 1'b0;
`endif

endmodule

// File: doc/fee_config_sequencer.md
Name: fee_config_sequencer

Overview:
- Sits between the AXI-Lite FEE config register bank and the trigger/acquisition datapath.
- Holds the datapath in STOP, drains in-flight triggers, and exposes the SET_CONFIG window.
- Latches the staged register values into the applied configuration.
- Releases the datapath into NORMAL or COMBINED run.
- No register value reaches the datapath while it is acquiring.

Parameters:
- DRAIN_TIMEOUT, 1024: max cycles waiting for DATAPATH_BUSY low in DRAIN.
- SETTLE_CYCLES, 4: cycles SET_CONFIG stays high in APPLY after the new values are latched; legal range 1..255.

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- REG_MODE  in  3  staged mode: 110 CONFIG, 010 STOP, 000 NORMAL, 001 COMBINED
- REG_MAX_TRIGGER_LENGTH  in  16  staged
- REG_RISING_EDGE_THRESHOLD  in  16  staged
- REG_FALLING_EDGE_THRESHOLD  in  16  staged
- REG_PRE_ACQUISITION_LENGTH  in  2  staged
- REG_POST_ACQUISITION_LENGTH  in  2  staged
- REG_H_GAIN_BASELINE  in  13  staged
- REG_L_GAIN_BASELINE  in  16  staged
- DATAPATH_BUSY  in  1  trigger in flight
- STOP  out  1  datapath halt
- SET_CONFIG  out  1  datapath config window
- ACQUIRE_MODE  out  1  0 normal, 1 combined
- MAX_TRIGGER_LENGTH, RISING_EDGE_THRESHOLD, FALLING_EDGE_THRESHOLD, PRE_ACQUISITION_LENGTH, POST_ACQUISITION_LENGTH, H_GAIN_BASELINE, L_GAIN_BASELINE  out  (widths as staged)  applied config
- SEQ_STATE  out  3  encoded state
- CONFIG_ERROR  out  1  sticky invalid-config flag
- DRAIN_TIMEOUT_ERR  out  1  sticky drain-timeout flag

Behaviour:
- Reset values:
  - STOP=1, SET_CONFIG=0, ACQUIRE_MODE=0, all applied config=0.
  - CONFIG_ERROR=0, DRAIN_TIMEOUT_ERR=0, state=STOPPED.
- Outputs are registered; state change is visible 1 cycle after the deciding input.
- Mode decode:
  - REG_MODE[2]=1 means config request; takes priority over all other bits.
  - Otherwise REG_MODE[1]=1 means stop.
  - Otherwise run, with ACQUIRE_MODE taken from REG_MODE[0].
- STOPPED (0): STOP=1, SET_CONFIG=0.
  - Config request goes to CONFIG.
  - Run request goes to APPLY.
- RUN (1): STOP=0, SET_CONFIG=0.
  - Config request, stop request, or REG_MODE[0]≠ACQUIRE_MODE goes to DRAIN.
- DRAIN (2): STOP=1.
  - Counter resets on entry.
  - When DATAPATH_BUSY=0: config request goes to CONFIG, stop request goes to STOPPED, run request goes to APPLY.
  - If the counter reaches DRAIN_TIMEOUT: set DRAIN_TIMEOUT_ERR and take the same exit.
- CONFIG (3): STOP=1, SET_CONFIG=1.
  - Clears CONFIG_ERROR on entry.
  - Applied outputs are frozen; staged inputs are ignored.
  - When config request drops, go to APPLY.
- APPLY (4): STOP=1, SET_CONFIG=1.
  - On the entry cycle, latch all REG_* into the applied outputs; ACQUIRE_MODE=REG_MODE[0].
  - Hold for SETTLE_CYCLES, then evaluate:
    - Config request reappeared: go to CONFIG.
    - Stop request: go to STOPPED.
    - Run request with invalid config: go to STOPPED and set CONFIG_ERROR.
    - Run request with valid config: go to RUN.
  - Valid config means FALLING_EDGE_THRESHOLD ≤ RISING_EDGE_THRESHOLD (unsigned) and MAX_TRIGGER_LENGTH≠0.
- SEQ_STATE encodings: STOPPED 0, RUN 1, DRAIN 2, CONFIG 3, APPLY 4.
- STOP never deasserts while SET_CONFIG=1; SET_CONFIG never asserts while STOP=0.
- Staged-register changes during RUN have no effect until the next APPLY.
- RESET_N asserted mid-sequence forces the reset values immediately, including mid-DRAIN or mid-APPLY.
- Sticky errors clear only on reset (CONFIG_ERROR also on CONFIG entry).

Optional Feature:
- FEE_CFG_SEQ_DRAIN_TIMEOUT_EN defined:
  - DRAIN timeout counter (clog2(DRAIN_TIMEOUT+1) bits) present.
  - DRAIN_TIMEOUT_ERR behaves as above.
- Not defined:
  - No counter; DRAIN waits indefinitely for DATAPATH_BUSY=0.
  - DRAIN_TIMEOUT_ERR tied 0; DRAIN_TIMEOUT unused.

Test Plan:
1. Reset, then REG_MODE=110; load MAX=32, thresholds 1024/512, pre/post=1, baselines 1024/128; then REG_MODE=000.
   - CONFIG then APPLY.
   - Outputs match the loaded values one cycle after APPLY entry.
   - SET_CONFIG high for 1+SETTLE_CYCLES=5 cycles, then RUN with STOP=0, ACQUIRE_MODE=0.
2. In RUN with DATAPATH_BUSY=1, set REG_MODE=110 and hold BUSY 20 cycles.
   - STOP=1 the next cycle; SET_CONFIG stays 0 until BUSY falls; then CONFIG.
   - Applied outputs unchanged throughout.
3. Thresholds rising 512 / falling 1024, then 110→000.
   - STOPPED, CONFIG_ERROR=1, STOP stays 1.
   - Re-entering 110 clears CONFIG_ERROR.
4. In RUN, flip REG_MODE 000→001.
   - Sequence DRAIN→APPLY→RUN with ACQUIRE_MODE=1; thresholds unchanged unless staged regs changed.
5. With the macro and DRAIN_TIMEOUT=16, hold BUSY=1 and set REG_MODE=010.
   - DRAIN_TIMEOUT_ERR=1 after 16 cycles, then STOPPED.
   - Without the macro, the sequencer stays in DRAIN.
6. Assert RESET_N=0 for 1 cycle during APPLY.
   - Every output returns to its reset value immediately (async) and state=STOPPED.
